systolic_array_ctrl: RTL and testbench



---
 rtl/systolic_array_ctrl_pkg.sv | 25 ++
 rtl/systolic_array_ctrl_if.sv | 31 +++
 rtl/systolic_array_ctrl_wavefront.sv | 35 +++
 rtl/systolic_array_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_systolic_array_ctrl.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/systolic_array_ctrl_pkg.sv
// Shared types and helpers for the systolic array sequencer.
// SYSTOLIC_CTRL_PERF_EN (see top) enables the perf counters.
package systolic_pkg;

  localparam int DIM_DEF = 16;
  localparam int KW_DEF  = 10;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    EJECT,
    DONE
  } state_t;

  function automatic int pe_idx(
    input int i,
    input int j,
    input int dim
  );
    return i * dim + j;
  endfunction

endpackage

// File: rtl/systolic_array_ctrl_if.sv
// Operand request and result eject handshakes of the sequencer.
// master = sequencer, slave = fetch logic / result sink.
interface systolic_array_ctrl_if #(
  parameter int Dimension = systolic_pkg::DIM_DEF
);

  localparam int IW = $clog2(Dimension);

  logic          operand_req;
  logic          operand_valid;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_idx;

  modport master (
    output operand_req,
    output out_valid,
    output out_idx,
    input  operand_valid,
    input  out_ready
  );

  modport slave (
    input  operand_req,
    input  out_valid,
    input  out_idx,
    output operand_valid,
    output out_ready
  );

endinterface

// File: rtl/systolic_array_ctrl_wavefront.sv
// Skewed valid pipe: PE (i,j) accumulates when tap |i-j| is set.
// Shifts only on adv, so a stall freezes the whole wavefront.
module wavefront_valid_pipe
  import systolic_pkg::*;
#(
  parameter int Dimension = DIM_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           adv,
  input  logic                           vld_in,
  output logic [Dimension*Dimension-1:0] en_psum
);

  logic [Dimension-1:1] vld_q;
  logic [Dimension-1:0] vld;

  assign vld = {vld_q, vld_in};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
    end else if (adv) begin
      vld_q <= vld[Dimension-2:0];
    end
  end

  for (genvar i = 0; i < Dimension; i++) begin : g_row
    for (genvar j = 0; j < Dimension; j++) begin : g_col
      assign en_psum[pe_idx(i, j, Dimension)] =
        adv & vld[(i > j) ? i - j : j - i];
    end
  end

endmodule

// File: rtl/systolic_array_ctrl.sv
// Tile sequencer for the output-stationary systolic array.
// Define SYSTOLIC_CTRL_PERF_EN to build the busy/stall counters.
module systolic_array_ctrl
  import systolic_pkg::*;
#(
  parameter int Dimension = DIM_DEF,
  parameter int KW        = KW_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [KW-1:0]                  k_len,
  input  logic [Dimension-1:0]           cfg_ifmap_sel,
  systolic_array_ctrl_if.master          hs,
  output logic [Dimension*Dimension-1:0] en_in,
  output logic [Dimension*Dimension-1:0] en_psum,
  output logic [Dimension*Dimension-1:0] en_out,
  output logic [Dimension*Dimension-1:0] clear_psum,
  output logic [Dimension-1:0]           ifmaps_sel,
  output logic [Dimension-1:0]           output_eject_ctrl,
  output logic                           busy,
  output logic                           done,
  output logic [31:0]                    perf_busy_cycles,
  output logic [31:0]                    perf_stall_cycles
);

  localparam int N  = Dimension * Dimension;
  localparam int IW = $clog2(Dimension);

  state_t         state;
  state_t         state_nx;
  logic [KW-1:0]  k_q;
  logic [KW-1:0]  feed_cnt;
  logic [Dimension-1:0] sel_q;
  logic [IW-1:0]  drain_cnt;
  logic [IW-1:0]  out_idx_q;
  logic           req;
  logic           adv;
  logic           vld_in;
  logic           take;
  logic           row_acc;
  logic           last_row;
  logic           last_drain;
  logic           last_out;

  assign req = (state == FEED) && (feed_cnt < k_q);
  assign adv = (req & hs.operand_valid) | (state == DRAIN);
  assign vld_in = adv & (state == FEED) & hs.operand_valid;
  assign take = start & (state == IDLE);
  assign row_acc = (state == EJECT) & hs.out_ready;
  assign last_row = feed_cnt == k_q - KW'(1);
  assign last_drain = drain_cnt == IW'(Dimension - 2);
  assign last_out = out_idx_q == IW'(Dimension - 1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (start) begin
          state_nx = (k_len == '0) ? DONE : CLEAR;
        end
      CLEAR: state_nx = FEED;
      FEED:
        if (adv && last_row) begin
          state_nx = DRAIN;
        end
      DRAIN:
        if (last_drain) begin
          state_nx = EJECT;
        end
      EJECT:
        if (row_acc && last_out) begin
          state_nx = DONE;
        end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    clear_psum        = '0;
    output_eject_ctrl = '0;
    en_out            = '0;
    hs.out_valid      = 1'b0;
    busy              = 1'b1;
    done              = 1'b0;
    unique case (1'b1)
      (state == IDLE):  busy = 1'b0;
      (state == CLEAR): clear_psum = '1;
      (state == FEED):  ;
      (state == DRAIN): ;
      (state == EJECT): begin
        output_eject_ctrl = '1;
        hs.out_valid      = 1'b1;
        en_out            = {N{hs.out_ready}};
      end
      (state == DONE):  done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // Datapath counters; the latched config lives for the whole tile.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k_q       <= '0;
      sel_q     <= '0;
      feed_cnt  <= '0;
      drain_cnt <= '0;
      out_idx_q <= '0;
    end else begin
      if (take) begin
        k_q       <= k_len;
        sel_q     <= cfg_ifmap_sel;
        feed_cnt  <= '0;
        out_idx_q <= '0;
      end
      if (state == FEED && adv) begin
        feed_cnt <= feed_cnt + 1'b1;
      end
      drain_cnt <= (state == DRAIN) ? drain_cnt + 1'b1 : '0;
      if (row_acc) begin
        out_idx_q <= last_out ? '0 : out_idx_q + 1'b1;
      end
    end
  end

  assign hs.operand_req = req;
  assign hs.out_idx     = out_idx_q;
  assign en_in          = {N{adv}};
  assign ifmaps_sel     = sel_q;

  wavefront_valid_pipe #(
    .Dimension(Dimension)
  ) u_pipe (
    .clk    (clk),
    .rst    (rst),
    .adv    (adv),
    .vld_in (vld_in),
    .en_psum(en_psum)
  );

`ifdef SYSTOLIC_CTRL_PERF_EN
  logic [31:0] pb_q;
  logic [31:0] ps_q;
  logic        stall;

  assign stall = ((state == FEED) & ~hs.operand_valid)
               | ((state == EJECT) & ~hs.out_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pb_q <= '0;
      ps_q <= '0;
    end else if (take) begin
      pb_q <= '0;
      ps_q <= '0;
    end else begin
      if (state != IDLE && pb_q != '1) begin
        pb_q <= pb_q + 1'b1;
      end
      if (stall && ps_q != '1) begin
        ps_q <= ps_q + 1'b1;
      end
    end
  end

  assign perf_busy_cycles  = pb_q;
  assign perf_stall_cycles = ps_q;
`else
  assign perf_busy_cycles  = '0;
  assign perf_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Self-checking bench for systolic_array_ctrl (Dimension 16, KW 10).
// Vector table per tile plus a scoreboard of expected eject indices.
module tb_systolic_array_ctrl;

  localparam int D    = 16;
  localparam int KW   = 10;
  localparam int N    = D * D;
  localparam int P015 = 15;

  typedef struct {
    int k;
    int st_at;
    int st_len;
    bit bp;
    int ex_busy;
    int ex_first;
    int ex_last;
    int ex_stall;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [KW-1:0] k_len = '0;
  logic [D-1:0]  cfg_sel = '0;
  logic [N-1:0]  en_in;
  logic [N-1:0]  en_psum;
  logic [N-1:0]  en_out;
  logic [N-1:0]  clear_psum;
  logic [D-1:0]  ifmaps_sel;
  logic [D-1:0]  eject;
  logic          busy;
  logic          done;
  logic [31:0]   pb;
  logic [31:0]   ps;

  systolic_array_ctrl_if #(.Dimension(D)) hs();

  systolic_array_ctrl #(
    .Dimension(D),
    .KW       (KW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .k_len            (k_len),
    .cfg_ifmap_sel    (cfg_sel),
    .hs               (hs),
    .en_in            (en_in),
    .en_psum          (en_psum),
    .en_out           (en_out),
    .clear_psum       (clear_psum),
    .ifmaps_sel       (ifmaps_sel),
    .output_eject_ctrl(eject),
    .busy             (busy),
    .done             (done),
    .perf_busy_cycles (pb),
    .perf_stall_cycles(ps)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int tcyc = 0;
  int busy_n, done_n, done_cyc, acc_n;
  int enin_n, req_n, clr_n, frz_bad, out_bad;
  int first_c, last_c;
  int pcnt[N];
  int sb[$];

  task automatic check(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    busy_n = 0; done_n = 0; done_cyc = -1; acc_n = 0;
    enin_n = 0; req_n = 0; clr_n = 0; frz_bad = 0; out_bad = 0;
    first_c = -1; last_c = -1;
    for (int p = 0; p < N; p++) pcnt[p] = 0;
  endtask

  function automatic logic any_out();
    return |{en_in, en_psum, en_out, clear_psum, ifmaps_sel, eject,
             hs.out_valid, hs.out_idx, hs.operand_req, busy, done, pb, ps};
  endfunction

  // Cycle 1 is the first cycle after the edge that samples start.
  always @(posedge clk) begin
    if (start && !busy) tcyc <= 1;
    else tcyc <= tcyc + 1;
  end

  always @(negedge clk) begin
    if (rst) begin
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        done_cyc = tcyc;
      end
      if (|en_in) enin_n++;
      if (hs.operand_req) req_n++;
      if (|clear_psum) clr_n++;
      if (!hs.operand_valid && (|en_in || |en_psum)) frz_bad++;
      if (hs.out_valid && !hs.out_ready && |en_out) out_bad++;
      if (hs.out_valid && hs.out_ready && !(&en_out)) out_bad++;
      if (!hs.out_valid && |en_out) out_bad++;
      for (int p = 0; p < N; p++) if (en_psum[p]) pcnt[p]++;
      if (en_psum[P015]) begin
        if (first_c < 0) first_c = tcyc;
        last_c = tcyc;
      end
      if (hs.out_valid && hs.out_ready) begin
        acc_n++;
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL sb_underflow: got row %0d expected none", hs.out_idx);
        end else begin
          check("out_idx", hs.out_idx, sb.pop_front());
        end
      end
    end
  end

  task automatic run_vec(input vec_t v);
    logic [D-1:0] exp_sel;
    bit ph;
    int bad;
    ph = 1'b1;
    tick();
    clear_stats();
    if (v.k > 0) for (int i = 0; i < D; i++) sb.push_back(i);
    exp_sel = 16'hA5A5 ^ 16'(v.k);
    cfg_sel = exp_sel;
    k_len = KW'(v.k);
    start = 1'b1;
    tick();
    start = 1'b0;
    k_len = KW'(5);
    cfg_sel = ~exp_sel;
    for (int c = 0; c < 3000 && !(done_n > 0 && !busy); c++) begin
      hs.operand_valid = !(tcyc >= v.st_at && tcyc < v.st_at + v.st_len);
      if (hs.out_valid) begin
        hs.out_ready = v.bp ? ph : 1'b1;
        ph = !ph;
      end else begin
        hs.out_ready = 1'b1;
      end
      start = (tcyc == 3) && busy;
      tick();
    end
    start = 1'b0;
    hs.operand_valid = 1'b1;
    hs.out_ready = 1'b1;
    check("done_pulses", done_n, 1);
    check("busy_cycles", busy_n, v.ex_busy);
    check("done_cycle", done_cyc, v.ex_busy);
    check("rows_accepted", acc_n, (v.k > 0) ? D : 0);
    check("sb_left", sb.size(), 0);
    check("en_in_cycles", enin_n, (v.k > 0) ? v.k + D - 1 : 0);
    check("req_cycles", req_n, v.k + v.st_len);
    check("clear_cycles", clr_n, (v.k > 0) ? 1 : 0);
    bad = 0;
    for (int p = 0; p < N; p++) if (pcnt[p] != v.k) bad++;
    check("pe_acc_count_bad", bad, 0);
    check("pe0_15_first", first_c, v.ex_first);
    check("pe0_15_last", last_c, v.ex_last);
    check("freeze_viol", frz_bad, 0);
    check("en_out_viol", out_bad, 0);
    check("ifmaps_sel", ifmaps_sel, exp_sel);
`ifdef SYSTOLIC_CTRL_PERF_EN
    check("perf_busy", pb, v.ex_busy);
    check("perf_stall", ps, v.ex_stall);
`else
    check("perf_busy", pb, 0);
    check("perf_stall", ps, 0);
`endif
  endtask

  vec_t vt[7];

  initial begin
    vec_t rv;
    vt[0] = '{8,    0, 0, 1'b0, 41,   17, 24,   0};
    vt[1] = '{4,    4, 3, 1'b0, 40,   20, 23,   3};
    vt[2] = '{8,    0, 0, 1'b1, 56,   17, 24,   15};
    vt[3] = '{0,    0, 0, 1'b0, 1,    -1, -1,   0};
    vt[4] = '{1,    0, 0, 1'b0, 34,   17, 17,   0};
    vt[5] = '{3,    2, 1, 1'b0, 37,   18, 20,   1};
    vt[6] = '{1023, 0, 0, 1'b0, 1056, 17, 1039, 0};
    hs.operand_valid = 1'b1;
    hs.out_ready = 1'b1;
    #12;
    check("reset_outputs", any_out(), 0);
    rst = 1'b1;
    for (int i = 0; i < 7; i++) run_vec(vt[i]);

    // Reset in the middle of DRAIN, then a short tile.
    tick();
    clear_stats();
    k_len = KW'(8);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 100 && tcyc < 12; c++) tick();
    check("in_drain_busy", busy, 1);
    #2 rst = 1'b0;
    #1 check("async_reset_outputs", any_out(), 0);
    tick();
    rst = 1'b1;
    sb.delete();
    rv = '{2, 0, 0, 1'b0, 35, 17, 18, 0};
    run_vec(rv);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
